// File: rtl/hamming_pkg.sv
// Shared definitions for the extended Hamming(16,11) SECDED link: sizes,
// parity positions, data-to-position map and the reference encode function.
package hamming_pkg;

  localparam int unsigned CODE_W  = 16;
  localparam int unsigned DATA_W  = 11;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned NUM_PAR = 4;

  localparam int unsigned P0_POS = 0;
  localparam int unsigned P1_POS = 1;
  localparam int unsigned P2_POS = 2;
  localparam int unsigned P4_POS = 4;
  localparam int unsigned P8_POS = 8;

  // din[i] lands at codeword position DATA_POS[i]
  localparam int unsigned DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  typedef logic [CODE_W-1:0] codeword_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  pos_t;

  typedef struct packed {
    logic  inj_en;
    pos_t  inj_pos;
    data_t data;
  } tx_req_t;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  // Position 0 carries overall parity so the full word has even weight.
  function automatic codeword_t hamming_encode(input data_t d);
    codeword_t cw;
    logic      p;
    cw = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      cw[CNT_W'(DATA_POS[i])] = d[i];
    end
    for (int unsigned k = 0; k < NUM_PAR; k++) begin
      p = 1'b0;
      for (int unsigned j = 1; j < CODE_W; j++) begin
        if ((((j >> k) & 32'd1) != 32'd0) && (j != (32'd1 << k))) begin
          p = p ^ cw[CNT_W'(j)];
        end
      end
      cw[CNT_W'(32'd1 << k)] = p;
    end
    cw[CNT_W'(P0_POS)] = ^cw[CODE_W-1:1];
    return cw;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational encode of an 11-bit data word into the 16-bit SECDED codeword.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  data_t     din,
  output codeword_t codeword_c
);

  assign codeword_c = hamming_encode(din);

endmodule

// File: rtl/hamming_encoder_tx.sv
// Serial Hamming(16,11) SECDED transmitter: accepts a word via valid/ready,
// optionally flips one codeword bit, and shifts the codeword out LSB first.
module hamming_encoder_tx
  import hamming_pkg::*;
#(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  input  logic              inj_en,
  input  logic [CNT_W-1:0]  inj_pos,
  output logic              dataout,
  output logic              dvalid,
  output logic              sof
);

  state_e    state_q, state_d;
  pos_t      count_q, count_d;
  codeword_t shreg_q, shreg_d;
  logic      dataout_q, dataout_d;
  logic      dvalid_q, dvalid_d;
  logic      sof_q, sof_d;

  tx_req_t   req_c;
  codeword_t enc_c;
  codeword_t load_cw_c;
  logic      last_c;
  logic      accept_c;

  assign req_c = '{inj_en: inj_en, inj_pos: inj_pos, data: din};

  hamming_parity_gen u_parity_gen (
    .din        (req_c.data),
    .codeword_c (enc_c)
  );

  // Injection sits after parity generation so the decoder sees a true error.
  assign load_cw_c = enc_c ^ (CODE_W'(req_c.inj_en) << req_c.inj_pos);

  assign last_c   = (count_q == CNT_W'(CODE_W - 1));
  assign ready    = (state_q == ST_IDLE) || last_c;
  assign accept_c = load && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      shreg_q   <= '0;
      dataout_q <= IDLE_LEVEL;
      dvalid_q  <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      dataout_q <= dataout_d;
      dvalid_q  <= dvalid_d;
      sof_q     <= sof_d;
    end
  end

  // count_q always names the codeword position currently on dataout.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    shreg_d   = shreg_q;
    dataout_d = IDLE_LEVEL;
    dvalid_d  = 1'b0;
    sof_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d   = ST_SHIFT;
          count_d   = '0;
          shreg_d   = load_cw_c;
          dataout_d = load_cw_c[0];
          dvalid_d  = 1'b1;
          sof_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!last_c) begin
          count_d   = count_q + CNT_W'(1);
          shreg_d   = shreg_q >> 1;
          dataout_d = shreg_q[1];
          dvalid_d  = 1'b1;
        end else if (accept_c) begin
          count_d   = '0;
          shreg_d   = load_cw_c;
          dataout_d = load_cw_c[0];
          dvalid_d  = 1'b1;
          sof_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
          count_d = '0;
          shreg_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        shreg_d = '0;
      end
    endcase
  end

  assign dataout = dataout_q;
  assign dvalid  = dvalid_q;
  assign sof     = sof_q;

endmodule
